// File: rtl/axi_mux_aw_w_arbiter.sv
// axi_mux_aw_w_arbiter
// Control block of an AXI mux: arbitrates NoSlvPorts upstream AW channels
// onto one downstream AW and routes W beats in AW order through a small
// FIFO of granted port indices. Payload muxing lives outside this block and
// is driven from aw_sel_o / w_sel_o.
// Optional feature: define AXI_MUX_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed lowest-index-wins priority.
module axi_mux_aw_w_arbiter #(
  parameter int unsigned NoSlvPorts = 4,
  parameter int unsigned MaxWTrans  = 8,
  parameter int unsigned SelWidth   = $clog2(NoSlvPorts)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NoSlvPorts-1:0] slv_aw_valid_i,
  output logic [NoSlvPorts-1:0] slv_aw_ready_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output logic [SelWidth-1:0]   aw_sel_o,
  input  logic [NoSlvPorts-1:0] slv_w_valid_i,
  input  logic [NoSlvPorts-1:0] slv_w_last_i,
  output logic [NoSlvPorts-1:0] slv_w_ready_o,
  output logic                  mst_w_valid_o,
  input  logic                  mst_w_ready_i,
  output logic [SelWidth-1:0]   w_sel_o,
  output logic                  w_fifo_full_o,
  output logic                  w_fifo_empty_o
);

  localparam int unsigned PtrWidth = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam int unsigned CntWidth = $clog2(MaxWTrans + 1);

  typedef logic [SelWidth-1:0] sel_t;
  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic {
    AW_IDLE,
    AW_LOCKED
  } aw_state_e;

  aw_state_e state_q, state_d;
  sel_t      grant_q, grant_d;
  sel_t      arb_grant;
  logic      arb_found;

`ifndef AXI_MUX_FIXED_PRIO_EN
  sel_t      rr_ptr_q, rr_ptr_d;
`endif

  // W-route FIFO storage and bookkeeping
  sel_t      fifo_mem [MaxWTrans];
  ptr_t      rd_ptr_q, wr_ptr_q;
  cnt_t      count_q;
  logic      fifo_full, fifo_empty;
  logic      push, pop;
  sel_t      push_port;
  sel_t      head;

  assign fifo_full      = (count_q == cnt_t'(MaxWTrans));
  assign fifo_empty     = (count_q == '0);
  assign w_fifo_full_o  = fifo_full;
  assign w_fifo_empty_o = fifo_empty;
  assign head           = fifo_mem[rd_ptr_q];

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxWTrans - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Pick the requesting port that would win arbitration this cycle
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    arb_found = 1'b0;
    arb_grant = '0;
    for (int i = 0; i < int'(NoSlvPorts); i++) begin
`ifdef AXI_MUX_FIXED_PRIO_EN
      if (!arb_found && slv_aw_valid_i[i]) begin
        arb_found = 1'b1;
        arb_grant = sel_t'(i);
      end
`else
      if (!arb_found &&
          slv_aw_valid_i[(int'(rr_ptr_q) + i) % int'(NoSlvPorts)]) begin
        arb_found = 1'b1;
        arb_grant = sel_t'((int'(rr_ptr_q) + i) % int'(NoSlvPorts));
      end
`endif
    end
  end

  // AW grant FSM: zero-latency grant in idle, grant held until handshake
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    aw_sel_o       = '0;
    mst_aw_valid_o = 1'b0;
    slv_aw_ready_o = '0;
    push           = 1'b0;
    push_port      = grant_q;
    case (state_q)
      AW_IDLE: begin
        if (arb_found && !fifo_full) begin
          mst_aw_valid_o            = 1'b1;
          aw_sel_o                  = arb_grant;
          slv_aw_ready_o[arb_grant] = mst_aw_ready_i;
          push_port                 = arb_grant;
          if (mst_aw_ready_i) begin
            push = 1'b1;
          end else begin
            state_d = AW_LOCKED;
            grant_d = arb_grant;
          end
        end
      end
      AW_LOCKED: begin
        aw_sel_o = grant_q;
        // A full route FIFO stalls even a locked grant until a W burst ends.
        if (!fifo_full) begin
          mst_aw_valid_o          = slv_aw_valid_i[grant_q];
          slv_aw_ready_o[grant_q] = mst_aw_ready_i;
          if (slv_aw_valid_i[grant_q] && mst_aw_ready_i) begin
            push    = 1'b1;
            state_d = AW_IDLE;
          end
        end
      end
      default: state_d = AW_IDLE;
    endcase
  end

`ifndef AXI_MUX_FIXED_PRIO_EN
  // Round-robin pointer moves just past the port that completed its AW
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (push_port == sel_t'(NoSlvPorts - 1)) ? '0
                                                       : push_port + sel_t'(1);
    end
  end
`endif

  // W steering from the FIFO head; pop on the last beat's handshake
  always_comb begin
    w_sel_o       = '0;
    mst_w_valid_o = 1'b0;
    slv_w_ready_o = '0;
    pop           = 1'b0;
    if (!fifo_empty) begin
      w_sel_o             = head;
      mst_w_valid_o       = slv_w_valid_i[head];
      slv_w_ready_o[head] = mst_w_ready_i;
      pop = slv_w_valid_i[head] & mst_w_ready_i & slv_w_last_i[head];
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (rst_i) begin
      state_q  <= AW_IDLE;
      grant_q  <= '0;
`ifndef AXI_MUX_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
`ifndef AXI_MUX_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; entries are only read while the
    // count marks them valid, so clearing them would buy nothing.
    if (push) fifo_mem[wr_ptr_q] <= push_port;
  end

`ifndef SYNTHESIS
  // Route FIFO must never overflow or underflow
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && fifo_full))  else $error("route FIFO push while full");
      assert (!(pop && fifo_empty))  else $error("route FIFO pop while empty");
    end
  end
`endif

endmodule

// File: tb/tb_axi_mux_aw_w_arbiter.sv
// Directed testbench for axi_mux_aw_w_arbiter (4 ports, route FIFO depth 3).
module tb_axi_mux_aw_w_arbiter;

  localparam int unsigned NoSlvPorts = 4;
  localparam int unsigned MaxWTrans  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] aw_valid = '0;
  logic [3:0] aw_ready;
  logic       mst_aw_valid;
  logic       mst_aw_ready = 1'b0;
  logic [1:0] aw_sel;
  logic [3:0] w_valid = '0;
  logic [3:0] w_last = '0;
  logic [3:0] w_ready;
  logic       mst_w_valid;
  logic       mst_w_ready = 1'b0;
  logic [1:0] w_sel;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_mux_aw_w_arbiter #(
    .NoSlvPorts(NoSlvPorts),
    .MaxWTrans (MaxWTrans)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slv_aw_valid_i(aw_valid),
    .slv_aw_ready_o(aw_ready),
    .mst_aw_valid_o(mst_aw_valid),
    .mst_aw_ready_i(mst_aw_ready),
    .aw_sel_o      (aw_sel),
    .slv_w_valid_i (w_valid),
    .slv_w_last_i  (w_last),
    .slv_w_ready_o (w_ready),
    .mst_w_valid_o (mst_w_valid),
    .mst_w_ready_i (mst_w_ready),
    .w_sel_o       (w_sel),
    .w_fifo_full_o (full),
    .w_fifo_empty_o(empty)
  );

  // Observed AW side: {valid, sel, ready[3:0]}
  function automatic logic [6:0] aw_obs();
    return {mst_aw_valid, aw_sel, aw_ready};
  endfunction

  // Observed W side: {valid, sel, ready[3:0], full, empty}
  function automatic logic [8:0] w_obs();
    return {mst_w_valid, w_sel, w_ready, full, empty};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    aw_valid     = '0;
    mst_aw_ready = 1'b0;
    w_valid      = '0;
    w_last       = '0;
    mst_w_ready  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (aw_obs() !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL reset_aw: got %b expected %b", aw_obs(), 7'b0_00_0000);
    end
    checks++;
    if (w_obs() !== 9'b0_00_0000_0_1) begin
      errors++;
      $display("FAIL reset_w: got %b expected %b", w_obs(), 9'b0_00_0000_0_1);
    end
  endtask

  // Ports 0,1,2 together, then port 3 blocked by a full FIFO until the
  // first W-last pop; W bursts drain in order 0,1,2,3 with FIFO wrap.
  task automatic test_rr_full();
    logic [3:0] av  [11] = '{4'b0111, 4'b0110, 4'b0100, 4'b1000, 4'b1000, 4'b1000,
                             4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] wv  [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF,
                             4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [3:0] wl  [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF,
                             4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [6:0] eaw [11] = '{7'b1_00_0001, 7'b1_01_0010, 7'b1_10_0100, 7'b0_00_0000,
                             7'b0_00_0000, 7'b0_00_0000, 7'b1_11_1000, 7'b0_00_0000,
                             7'b0_00_0000, 7'b0_00_0000, 7'b0_00_0000};
    logic [8:0] ew  [11] = '{9'b0_00_0000_0_1, 9'b0_00_0001_0_0, 9'b0_00_0001_0_0,
                             9'b0_00_0001_1_0, 9'b1_00_0001_1_0, 9'b1_00_0001_1_0,
                             9'b1_01_0010_0_0, 9'b1_01_0010_1_0, 9'b1_10_0100_0_0,
                             9'b1_11_1000_0_0, 9'b0_00_0000_0_1};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      aw_valid     = av[c];
      mst_aw_ready = 1'b1;
      w_valid      = wv[c];
      w_last       = wl[c];
      mst_w_ready  = 1'b1;
      #1;
      checks++;
      if (aw_obs() !== eaw[c]) begin
        errors++;
        $display("FAIL rr_full_aw c%0d: got %b expected %b", c, aw_obs(), eaw[c]);
      end
      checks++;
      if (w_obs() !== ew[c]) begin
        errors++;
        $display("FAIL rr_full_w c%0d: got %b expected %b", c, w_obs(), ew[c]);
      end
    end
  endtask

  // Port 3 locked with downstream not ready for 5 cycles while port 0 also
  // requests; port 3 completes on cycle 6, then port 0 wins.
  task automatic test_locked();
    logic [3:0] av  [8] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001,
                            4'b1001, 4'b1001, 4'b0001, 4'b0000};
    logic       ar  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [6:0] eaw [8] = '{7'b1_11_0000, 7'b1_11_0000, 7'b1_11_0000, 7'b1_11_0000,
                            7'b1_11_0000, 7'b1_11_1000, 7'b1_00_0001, 7'b0_00_0000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      aw_valid     = av[c];
      mst_aw_ready = ar[c];
      #1;
      checks++;
      if (aw_obs() !== eaw[c]) begin
        errors++;
        $display("FAIL locked_aw c%0d: got %b expected %b", c, aw_obs(), eaw[c]);
      end
    end
    // FIFO now holds {3,0}; head is port 3, W idle
    checks++;
    if (w_obs() !== 9'b0_11_0000_0_0) begin
      errors++;
      $display("FAIL locked_w_head: got %b expected %b", w_obs(), 9'b0_11_0000_0_0);
    end
  endtask

  // W beat present in the AW handshake cycle is only steered one cycle later
  task automatic test_w_same_cycle();
    logic [3:0] av  [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic [6:0] eaw [3] = '{7'b1_10_0100, 7'b0_00_0000, 7'b0_00_0000};
    logic [8:0] ew  [3] = '{9'b0_00_0000_0_1, 9'b1_10_0100_0_0, 9'b0_00_0000_0_1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      aw_valid     = av[c];
      mst_aw_ready = 1'b1;
      w_valid      = 4'b0100;
      w_last       = 4'b0100;
      mst_w_ready  = 1'b1;
      #1;
      checks++;
      if (aw_obs() !== eaw[c]) begin
        errors++;
        $display("FAIL same_cycle_aw c%0d: got %b expected %b", c, aw_obs(), eaw[c]);
      end
      checks++;
      if (w_obs() !== ew[c]) begin
        errors++;
        $display("FAIL same_cycle_w c%0d: got %b expected %b", c, w_obs(), ew[c]);
      end
    end
  endtask

  // Count 1 with a W-last pop and an AW push together: count stays 1,
  // head becomes the newly pushed port.
  task automatic test_push_pop();
    logic [3:0] av  [5] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] wv  [5] = '{4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0000};
    logic [3:0] wl  [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    logic [6:0] eaw [5] = '{7'b1_01_0010, 7'b1_10_0100, 7'b0_00_0000,
                            7'b0_00_0000, 7'b0_00_0000};
    logic [8:0] ew  [5] = '{9'b0_00_0000_0_1, 9'b1_01_0010_0_0, 9'b1_10_0100_0_0,
                            9'b1_10_0100_0_0, 9'b0_00_0000_0_1};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      aw_valid     = av[c];
      mst_aw_ready = 1'b1;
      w_valid      = wv[c];
      w_last       = wl[c];
      mst_w_ready  = 1'b1;
      #1;
      checks++;
      if (aw_obs() !== eaw[c]) begin
        errors++;
        $display("FAIL push_pop_aw c%0d: got %b expected %b", c, aw_obs(), eaw[c]);
      end
      checks++;
      if (w_obs() !== ew[c]) begin
        errors++;
        $display("FAIL push_pop_w c%0d: got %b expected %b", c, w_obs(), ew[c]);
      end
    end
  endtask

  // Reset after two beats of a burst while port 3 holds a locked AW
  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk);
    aw_valid     = 4'b0001;
    mst_aw_ready = 1'b1;
    #1;
    checks++;
    if (aw_obs() !== 7'b1_00_0001) begin
      errors++;
      $display("FAIL mid_burst_push: got %b expected %b", aw_obs(), 7'b1_00_0001);
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      aw_valid     = 4'b1000;
      mst_aw_ready = 1'b0;
      w_valid      = 4'b0001;
      w_last       = 4'b0000;
      mst_w_ready  = 1'b1;
      #1;
      checks++;
      if (aw_obs() !== 7'b1_11_0000) begin
        errors++;
        $display("FAIL mid_burst_lock b%0d: got %b expected %b", b, aw_obs(), 7'b1_11_0000);
      end
      checks++;
      if (w_obs() !== 9'b1_00_0001_0_0) begin
        errors++;
        $display("FAIL mid_burst_beat b%0d: got %b expected %b", b, w_obs(), 9'b1_00_0001_0_0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    aw_valid     = '0;
    mst_aw_ready = 1'b0;
    w_valid      = '0;
    w_last       = '0;
    mst_w_ready  = 1'b0;
    #1;
    checks++;
    if ({aw_obs(), w_obs()} !== {7'b0_00_0000, 9'b0_00_0000_0_1}) begin
      errors++;
      $display("FAIL after_reset_outputs: got %b expected %b",
               {aw_obs(), w_obs()}, {7'b0_00_0000, 9'b0_00_0000_0_1});
    end
    // Locked grant and pending burst are gone: port 0 wins from idle and
    // its W beat is held back because the route FIFO is empty.
    @(negedge clk);
    aw_valid    = 4'b0001;
    w_valid     = 4'b0001;
    mst_w_ready = 1'b1;
    #1;
    checks++;
    if (aw_obs() !== 7'b1_00_0000) begin
      errors++;
      $display("FAIL after_reset_aw: got %b expected %b", aw_obs(), 7'b1_00_0000);
    end
    checks++;
    if (w_obs() !== 9'b0_00_0000_0_1) begin
      errors++;
      $display("FAIL after_reset_w: got %b expected %b", w_obs(), 9'b0_00_0000_0_1);
    end
  endtask

  // Ports 1 and 2 requesting continuously, with W draining alongside
  task automatic test_priority();
`ifdef AXI_MUX_FIXED_PRIO_EN
    logic [6:0] eaw [3] = '{7'b1_01_0010, 7'b1_01_0010, 7'b1_01_0010};
    logic [8:0] ew  [3] = '{9'b0_00_0000_0_1, 9'b1_01_0010_0_0, 9'b1_01_0010_0_0};
`else
    logic [6:0] eaw [3] = '{7'b1_01_0010, 7'b1_10_0100, 7'b1_01_0010};
    logic [8:0] ew  [3] = '{9'b0_00_0000_0_1, 9'b1_01_0010_0_0, 9'b1_10_0100_0_0};
`endif
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      aw_valid     = 4'b0110;
      mst_aw_ready = 1'b1;
      w_valid      = 4'hF;
      w_last       = 4'hF;
      mst_w_ready  = 1'b1;
      #1;
      checks++;
      if (aw_obs() !== eaw[c]) begin
        errors++;
        $display("FAIL priority_aw c%0d: got %b expected %b", c, aw_obs(), eaw[c]);
      end
      checks++;
      if (w_obs() !== ew[c]) begin
        errors++;
        $display("FAIL priority_w c%0d: got %b expected %b", c, w_obs(), ew[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_full();
    test_locked();
    test_w_same_cycle();
    test_push_pop();
    test_reset_mid_burst();
    test_priority();
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mux_aw_w_arbiter.md
Name: axi_mux_aw_w_arbiter

Overview:
- Control block for an AXI mux: shares one downstream AW/W channel pair between NoSlvPorts upstream requesters.
- Round-robin arbitration on AW, with the grant locked until the AW handshake completes.
- Records each granted port in an in-order W-route FIFO and steers W beats from the FIFO head until w_last.
- Drives only valid/ready steering and the datapath select lines; payload muxing is external, driven from aw_sel_o and w_sel_o.

Parameters:
- NoSlvPorts, 4: number of upstream requesters; legal range 2..16.
- MaxWTrans, 8: W-route FIFO depth, i.e. maximum AWs whose W bursts are not yet complete; legal range 1..32.
- SelWidth, $clog2(NoSlvPorts): select width; dependent, do not override.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- slv_aw_valid_i  in  NoSlvPorts  per-port AW valid.
- slv_aw_ready_o  out  NoSlvPorts  per-port AW ready.
- mst_aw_valid_o  out  1  downstream AW valid.
- mst_aw_ready_i  in  1  downstream AW ready.
- aw_sel_o  out  SelWidth  AW payload mux select; equals the granted port.
- slv_w_valid_i  in  NoSlvPorts  per-port W valid.
- slv_w_last_i  in  NoSlvPorts  per-port W last.
- slv_w_ready_o  out  NoSlvPorts  per-port W ready.
- mst_w_valid_o  out  1  downstream W valid.
- mst_w_ready_i  in  1  downstream W ready.
- w_sel_o  out  SelWidth  W payload mux select; equals the FIFO head.
- w_fifo_full_o  out  1  FIFO holds MaxWTrans entries.
- w_fifo_empty_o  out  1  FIFO holds 0 entries.

Behaviour:
- Reset values (rst_i high at a clock edge): AW state AW_IDLE, RR pointer 0, FIFO emptied, count 0.
  - Outputs immediately after reset: all valid/ready 0, aw_sel_o 0, w_sel_o 0, w_fifo_empty_o 1, w_fifo_full_o 0.
  - Reset asserted mid-burst or mid-AW discards all state. No partial handshake is completed.
- AW arbitration, state AW_IDLE:
  - Eligible when any slv_aw_valid_i bit is set and the FIFO is not full.
  - Grant goes to the first requesting port at or above the RR pointer, wrapping modulo NoSlvPorts.
  - Zero-latency: in the same cycle mst_aw_valid_o=1, aw_sel_o=grant, slv_aw_ready_o[grant]=mst_aw_ready_i. All other ready bits are 0.
  - If mst_aw_ready_i=1: handshake done, push grant into the FIFO, pointer <= (grant+1) mod NoSlvPorts, remain in AW_IDLE.
  - If mst_aw_ready_i=0: register the grant and go to AW_LOCKED.
- AW arbitration, state AW_LOCKED:
  - aw_sel_o holds the registered grant; mst_aw_valid_o=slv_aw_valid_i[grant]. The grant never changes while locked.
  - On mst_aw_ready_i=1: push grant, update pointer, return to AW_IDLE.
- Full FIFO: no new grant in AW_IDLE; all slv_aw_ready_o=0; mst_aw_valid_o=0.
  - An already-locked AW also stalls (mst_aw_valid_o=0) until an entry pops.
  - Fullness uses the registered count before any same-cycle pop (no pop-to-push bypass).
- W routing:
  - FIFO is non-fall-through: an entry pushed in cycle N steers W from cycle N+1.
  - FIFO non-empty: w_sel_o=head, mst_w_valid_o=slv_w_valid_i[head], slv_w_ready_o[head]=mst_w_ready_i, all other ready bits 0.
  - FIFO empty: mst_w_valid_o=0 and all slv_w_ready_o=0. W beats issued ahead of their AW wait.
  - Pop when mst_w_valid_o & mst_w_ready_i & slv_w_last_i[head].
- Simultaneous push and pop: count unchanged, pointers both advance.
- Count width is $clog2(MaxWTrans+1). Read/write pointers wrap modulo MaxWTrans; non-power-of-2 depths are supported.
- Assertion: push never occurs when full and pop never occurs when empty (simulation-only).

Optional Feature:
- Macro: AXI_MUX_FIXED_PRIO_EN.
- When defined: the RR pointer is removed and the grant is always the lowest-index requesting port. All other behaviour is unchanged.
- When undefined: round-robin as above.

Test Plan:
- Ports 0,1,2 assert AW together, mst_aw_ready_i=1 constant -> grants 0,1,2 on consecutive cycles; FIFO holds {0,1,2}; W bursts route in that order.
- Port 3 AW with mst_aw_ready_i=0 for 5 cycles while port 0 also raises valid -> aw_sel_o stays 3 throughout; port 3 handshakes on cycle 6; port 0 is granted next.
- MaxWTrans=2: issue two AWs with no W -> w_fifo_full_o=1 and a third AW is stalled; the W-last handshake on the head frees the AW grant the following cycle.
- AW handshake in cycle N while slv_w_valid_i for that port is high in cycle N -> mst_w_valid_o=0 in N, 1 in N+1.
- Count 1, with a W-last pop and an AW push in the same cycle -> count stays 1 and the head becomes the new port.
- Assert rst_i during a 4-beat burst after beat 2 -> next cycle all outputs are at reset values and w_fifo_empty_o=1. With AXI_MUX_FIXED_PRIO_EN defined, ports 1 and 2 requesting continuously -> port 1 always wins.
